// File: rtl/iobus_arb_pkg.sv
// Shared types and MMIO constants for the IOBUS arbiter.
// Optional lock mode: IOBUS_ARB_LOCK_EN.
package iobus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } arb_state_t;

  localparam int IOBUS_AW = 32;
  localparam int IOBUS_DW = 32;

  localparam logic [31:0] SWITCHES_AD = 32'h1100_0000;
  localparam logic [31:0] LEDS_AD     = 32'h1100_0020;
  localparam logic [31:0] SSEG_AD     = 32'h1100_0040;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iobus_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request after the
// last-served index, wrapping modulo N.
module rr_picker
  import iobus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/iobus_arbiter.sv
// Round-robin arbiter sharing one MMIO bus among NUM_REQ masters.
// Define IOBUS_ARB_LOCK_EN to honour REQ_LOCK bursts.
module iobus_arbiter
  import iobus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int AW       = IOBUS_AW,
  parameter int DW       = IOBUS_DW,
  parameter int LOCK_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_REQ-1:0]    REQ_VLD,
  input  logic [NUM_REQ-1:0]    REQ_WR,
  input  logic [NUM_REQ-1:0]    REQ_LOCK,
  input  logic [NUM_REQ*AW-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DW-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]    REQ_RDY,
  output logic [NUM_REQ-1:0]    RSP_VLD,
  output logic [DW-1:0]         RSP_RDATA,
  output logic [AW-1:0]         IOBUS_ADDR,
  output logic [DW-1:0]         IOBUS_OUT,
  output logic                  IOBUS_WR,
  input  logic [DW-1:0]         IOBUS_IN
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_t         state;
  logic [IW-1:0]      last;
  logic [IW-1:0]      win_q;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IW-1:0]      rr_idx;
  logic               rr_any;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      win;
  logic               any;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (REQ_VLD),
    .last (last),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .any  (rr_any)
  );

`ifdef IOBUS_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          lock_pend;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          lock_take;

  // A pending lock re-grants the previous winner ahead of RR.
  assign lock_take = lock_pend && REQ_VLD[last];
  assign cnt_nxt   = lock_take ? CW'(lock_cnt + 1'b1) : CW'(1);
  assign gnt = lock_take ? (NUM_REQ'(1) << last) : rr_gnt;
  assign win = lock_take ? last : rr_idx;
  assign any = lock_take | rr_any;
`else
  logic lock_unused;
  localparam int LOCK_MAX_UNUSED = LOCK_MAX;
  assign lock_unused = ^REQ_LOCK;
  assign gnt = rr_gnt;
  assign win = rr_idx;
  assign any = rr_any;
`endif

  assign sel_addr  = REQ_ADDR[int'(win) * AW +: AW];
  assign sel_wdata = REQ_WDATA[int'(win) * DW +: DW];
  assign REQ_RDY   = (state == IDLE) ? gnt : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      last       <= IW'(NUM_REQ - 1);
      win_q      <= '0;
      IOBUS_ADDR <= '0;
      IOBUS_OUT  <= '0;
      IOBUS_WR   <= 1'b0;
      RSP_VLD    <= '0;
      RSP_RDATA  <= '0;
`ifdef IOBUS_ARB_LOCK_EN
      lock_pend  <= 1'b0;
      lock_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            IOBUS_ADDR <= sel_addr;
            IOBUS_OUT  <= sel_wdata;
            IOBUS_WR   <= REQ_WR[win];
            win_q      <= win;
            last       <= win;
            state      <= BUS;
`ifdef IOBUS_ARB_LOCK_EN
            lock_cnt   <= cnt_nxt;
            lock_pend  <= REQ_LOCK[win] &&
                          (int'(cnt_nxt) < LOCK_MAX);
`endif
          end
        end
        BUS: begin
          RSP_VLD    <= NUM_REQ'(1) << win_q;
          RSP_RDATA  <= IOBUS_WR ? '0 : IOBUS_IN;
          IOBUS_ADDR <= '0;
          IOBUS_OUT  <= '0;
          IOBUS_WR   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          RSP_VLD   <= '0;
          RSP_RDATA <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_arbiter.sv
// Self-checking bench for iobus_arbiter (3 masters): vector table,
// corner sequences and randomized transactions against a reference model.
module tb_iobus_arbiter;
  import iobus_arb_pkg::*;

  localparam int N        = 3;
  localparam int LOCK_MAX = 4;

  logic          CLK;
  logic          RST_N;
  logic [N-1:0]  REQ_VLD, REQ_WR, REQ_LOCK;
  logic [N*32-1:0] REQ_ADDR, REQ_WDATA;
  logic [N-1:0]  REQ_RDY, RSP_VLD;
  logic [31:0]   RSP_RDATA, IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic          IOBUS_WR;

  int checks = 0;
  int failures = 0;

  int m_last;
`ifdef IOBUS_ARB_LOCK_EN
  bit m_lock_pend;
  int m_run;
`endif

  logic [63:0] wr_log[$];

  iobus_arbiter #(.NUM_REQ(N), .AW(32), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VLD(REQ_VLD), .REQ_WR(REQ_WR), .REQ_LOCK(REQ_LOCK),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_RDY(REQ_RDY), .RSP_VLD(RSP_VLD), .RSP_RDATA(RSP_RDATA),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN)
  );

  function automatic logic [31:0] bus_ref(input logic [31:0] a);
    return (a == SWITCHES_AD) ? 32'h0000_1234 : (a ^ 32'hC0DE_0000);
  endfunction

  assign IOBUS_IN = bus_ref(IOBUS_ADDR);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (RST_N && IOBUS_WR) wr_log.push_back({IOBUS_ADDR, IOBUS_OUT});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string n, input logic [63:0] a,
                              input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int lst);
    for (int k = 1; k <= N; k++) begin
      int j = (lst + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic clear_in();
    REQ_VLD = '0; REQ_WR = '0; REQ_LOCK = '0;
    REQ_ADDR = '0; REQ_WDATA = '0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    clear_in();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    m_last = N - 1;
`ifdef IOBUS_ARB_LOCK_EN
    m_lock_pend = 0;
    m_run = 0;
`endif
  endtask

  // One arbitration slot starting in IDLE; returns the DUT's observed winner.
  task automatic run_txn(input string tag, output int dut_win,
                         output logic [31:0] dut_rdata);
    int w;
    bit lk;
    logic [31:0] ea, ed, er;
    logic ew;
    logic [N-1:0] ordy;
    #1;
    lk = 0;
`ifdef IOBUS_ARB_LOCK_EN
    lk = m_lock_pend && REQ_VLD[m_last];
`endif
    w = lk ? m_last : pick(REQ_VLD, m_last);
    ordy = REQ_RDY;
    dut_win = -1;
    for (int i = N - 1; i >= 0; i--) if (ordy[i]) dut_win = i;
    dut_rdata = '0;
    chk({tag, "_rdy"}, 64'(ordy), (w < 0) ? 64'd0 : 64'(1) << w);
    if (w < 0) begin
      @(posedge CLK); #1;
      chk({tag, "_idle_wr"}, 64'(IOBUS_WR), 64'd0);
      return;
    end
    ea = REQ_ADDR[w*32 +: 32];
    ed = REQ_WDATA[w*32 +: 32];
    ew = REQ_WR[w];
    er = ew ? 32'd0 : bus_ref(ea);
    m_last = w;
`ifdef IOBUS_ARB_LOCK_EN
    m_run = lk ? m_run + 1 : 1;
    m_lock_pend = REQ_LOCK[w] && (m_run < LOCK_MAX);
`endif
    @(posedge CLK); #1;
    REQ_VLD = N'($urandom);
    REQ_WR = N'($urandom);
    REQ_ADDR = {$urandom, $urandom, $urandom};
    REQ_WDATA = {$urandom, $urandom, $urandom};
    #1;
    chk({tag, "_bus_rdy"}, 64'(REQ_RDY), 64'd0);
    chk({tag, "_bus_addr"}, 64'(IOBUS_ADDR), 64'(ea));
    chk({tag, "_bus_out"}, 64'(IOBUS_OUT), 64'(ed));
    chk({tag, "_bus_wr"}, 64'(IOBUS_WR), 64'(ew));
    chk({tag, "_bus_rsp"}, 64'(RSP_VLD), 64'd0);
    @(posedge CLK); #1;
    chk({tag, "_rsp_vld"}, 64'(RSP_VLD), 64'(1) << w);
    chk({tag, "_rsp_data"}, 64'(RSP_RDATA), 64'(er));
    chk({tag, "_rsp_wr"}, 64'(IOBUS_WR), 64'd0);
    chk({tag, "_rsp_addr"}, 64'(IOBUS_ADDR), 64'd0);
    dut_rdata = RSP_RDATA;
    clear_in();
    @(posedge CLK); #1;
    chk({tag, "_end_rsp"}, 64'(RSP_VLD), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           exp_win;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vt[7];
  int   dw;
  logic [31:0] dr;
  int   nlog;
  int   exp5[6];

  initial begin
    vt[0] = '{3'b001, 3'b001, LEDS_AD, 32'h0000_A5A5, 0, 32'h0};
    vt[1] = '{3'b010, 3'b000, SWITCHES_AD, 32'h0, 1, 32'h0000_1234};
    vt[2] = '{3'b111, 3'b000, SSEG_AD, 32'h0, 2, 32'hD1DE_0040};
    vt[3] = '{3'b111, 3'b111, 32'h1100_0060, 32'h55, 0, 32'h0};
    vt[4] = '{3'b000, 3'b000, 32'h0, 32'h0, -1, 32'h0};
    vt[5] = '{3'b110, 3'b000, SWITCHES_AD, 32'h0, 1, 32'h0000_1234};
    vt[6] = '{3'b101, 3'b000, LEDS_AD, 32'h0, 2, 32'hD1DE_0020};

    do_reset();
    #1;
    chk("rst_rdy", 64'(REQ_RDY), 64'd0);
    chk("rst_rsp", 64'(RSP_VLD), 64'd0);
    chk("rst_rdata", 64'(RSP_RDATA), 64'd0);
    chk("rst_bus", {IOBUS_ADDR, IOBUS_OUT}, 64'd0);
    chk("rst_wr", 64'(IOBUS_WR), 64'd0);

    foreach (vt[i]) begin
      REQ_VLD = vt[i].vld;
      REQ_WR = vt[i].wr;
      for (int m = 0; m < N; m++) begin
        REQ_ADDR[m*32 +: 32] = vt[i].addr;
        REQ_WDATA[m*32 +: 32] = vt[i].wdata;
      end
      run_txn($sformatf("vec%0d", i), dw, dr);
      chk($sformatf("vec%0d_win", i), 64'(dw), 64'(vt[i].exp_win));
      chk($sformatf("vec%0d_data", i), 64'(dr), 64'(vt[i].exp_rdata));
      if (i == 0)
        chk("vec0_wlog", wr_log[$], {LEDS_AD, 32'h0000_A5A5});
    end

    // Two masters contending: strict alternation, own read data
    do_reset();
    for (int i = 0; i < 6; i++) begin
      REQ_VLD = 3'b011;
      REQ_ADDR[0 +: 32] = SWITCHES_AD;
      REQ_ADDR[32 +: 32] = SSEG_AD;
      run_txn($sformatf("alt%0d", i), dw, dr);
      chk($sformatf("alt%0d_win", i), 64'(dw), 64'(i % 2));
      chk($sformatf("alt%0d_data", i), 64'(dr),
          (i % 2) ? 64'hD1DE_0040 : 64'h1234);
    end

    // Reset asserted during the BUS cycle of a write
    do_reset();
    REQ_VLD = 3'b001; REQ_WR = 3'b001;
    REQ_ADDR[0 +: 32] = LEDS_AD; REQ_WDATA[0 +: 32] = 32'hBEEF;
    #1 chk("abort_rdy", 64'(REQ_RDY), 64'd1);
    @(posedge CLK); #1;
    chk("abort_bus_wr", 64'(IOBUS_WR), 64'd1);
    nlog = wr_log.size();
    RST_N = 1'b0;
    clear_in();
    #1;
    chk("abort_wr_fall", 64'(IOBUS_WR), 64'd0);
    chk("abort_bus_clr", {IOBUS_ADDR, IOBUS_OUT}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("abort_rsp%0d", i), 64'(RSP_VLD), 64'd0);
    end
    chk("abort_nolog", 64'(wr_log.size()), 64'(nlog));
    RST_N = 1'b1;
    m_last = N - 1;
`ifdef IOBUS_ARB_LOCK_EN
    m_lock_pend = 0;
    m_run = 0;
`endif
    REQ_VLD = 3'b011;
    run_txn("abort_next", dw, dr);
    chk("abort_next_win", 64'(dw), 64'd0);

    // Request raised and dropped while busy leaves no trace
    do_reset();
    REQ_VLD = 3'b001;
    #1 chk("drop_rdy0", 64'(REQ_RDY), 64'd1);
    m_last = 0;
    @(posedge CLK); #1;
    REQ_VLD = 3'b010;
    #1 chk("drop_bus_rdy", 64'(REQ_RDY), 64'd0);
    @(posedge CLK); #1;
    chk("drop_rsp_rdy", 64'(REQ_RDY), 64'd0);
    REQ_VLD = 3'b000;
    @(posedge CLK); #1;
    chk("drop_idle_rdy", 64'(REQ_RDY), 64'd0);
    @(posedge CLK); #1;
    chk("drop_no_bus", {31'd0, IOBUS_WR, IOBUS_ADDR}, 64'd0);
    chk("drop_no_rsp", 64'(RSP_VLD), 64'd0);
    REQ_VLD = 3'b011;
    run_txn("drop_next", dw, dr);
    chk("drop_next_win", 64'(dw), 64'd1);

    // Master 1 holds the lock hint while both request
`ifdef IOBUS_ARB_LOCK_EN
    exp5 = '{0, 1, 1, 1, 1, 0};
`else
    exp5 = '{0, 1, 0, 1, 0, 1};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) begin
      REQ_VLD = 3'b011;
      REQ_LOCK = 3'b010;
      run_txn($sformatf("lock%0d", i), dw, dr);
      chk($sformatf("lock%0d_win", i), 64'(dw), 64'(exp5[i]));
    end

    do_reset();
    for (int i = 0; i < 150; i++) begin
      REQ_VLD = ($urandom_range(0, 5) == 0) ? 3'b000 : N'($urandom);
      REQ_WR = N'($urandom);
      REQ_LOCK = N'($urandom);
      for (int m = 0; m < N; m++) begin
        case ($urandom_range(0, 3))
          0: REQ_ADDR[m*32 +: 32] = SWITCHES_AD;
          1: REQ_ADDR[m*32 +: 32] = LEDS_AD;
          2: REQ_ADDR[m*32 +: 32] = SSEG_AD;
          default: REQ_ADDR[m*32 +: 32] = $urandom;
        endcase
        REQ_WDATA[m*32 +: 32] = $urandom;
      end
      run_txn($sformatf("rnd%0d", i), dw, dr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
